// File: rtl/param_multi_counter.sv
// Bank of independent up/down counters sharing one prescaler tick.
// Each channel supports load, stop-at-terminal or wrap/reload, and a terminal pulse.
module param_multi_counter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRE_W    = 8
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [PRE_W-1:0]          prescale_div,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dec,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       latch,
    input  logic [CHANNELS*WIDTH-1:0] in_value,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       zero,
    output logic [CHANNELS-1:0]       term_pulse
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    // Compare with >= so that shrinking the divisor mid-period ticks at once instead of wrapping.
    assign tick = (pre_cnt >= prescale_div);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] reload_q;
        logic             term_q;
        logic             step;
        logic [WIDTH-1:0] step_val;
        logic [WIDTH-1:0] term_val;
        logic             hit;

        assign step = tick && en[i] && !latch[i];

        always_comb begin
            step_val = cnt_q;
            term_val = dec[i] ? '0 : MAX_VAL;
            if (dec[i]) begin
                if (cnt_q != '0) begin
                    step_val = cnt_q - 1'b1;
                end else if (mode[i]) begin
                    step_val = reload_q;
                end else begin
                    step_val = '0;
                end
            end else begin
                if (cnt_q != MAX_VAL) begin
                    step_val = cnt_q + 1'b1;
                end else if (mode[i]) begin
                    step_val = '0;
                end else begin
                    step_val = MAX_VAL;
                end
            end
            // A stopped counter sitting on its terminal value must not pulse again.
            hit = (step_val == term_val) && ((cnt_q != term_val) || mode[i]);
        end

        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                cnt_q    <= '0;
                reload_q <= '0;
                term_q   <= 1'b0;
            end else if (latch[i]) begin
                cnt_q    <= in_value[i*WIDTH +: WIDTH];
                reload_q <= in_value[i*WIDTH +: WIDTH];
                term_q   <= 1'b0;
            end else if (step) begin
                cnt_q    <= step_val;
                term_q   <= hit;
            end else begin
                term_q   <= 1'b0;
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt_q;
        assign zero[i]                 = (cnt_q == '0);
        assign term_pulse[i]           = term_q;
    end

endmodule

// File: tb/tb_param_multi_counter.sv
// Testbench for param_multi_counter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_param_multi_counter;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int PRE_W    = 8;
    localparam int MAX_VAL  = (1 << WIDTH) - 1;

    logic                      clk_clk;
    logic                      reset_reset;
    logic [PRE_W-1:0]          prescale_div;
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       dec;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS-1:0]       latch;
    logic [CHANNELS*WIDTH-1:0] in_value;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       zero;
    logic [CHANNELS-1:0]       term_pulse;

    int n_compared;
    int n_mismatched;

    int m_count  [CHANNELS];
    int m_reload [CHANNELS];
    bit m_term   [CHANNELS];
    int m_pre;
    bit m_tick;
    bit model_valid;
    int m_cur;
    int m_nxt;
    int m_tv;

    int exp18_cnt  [5] = '{2, 1, 0, 3, 2};
    bit exp18_term [5] = '{0, 0, 1, 0, 0};

    param_multi_counter #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .PRE_W    (PRE_W)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .prescale_div (prescale_div),
        .en           (en),
        .dec          (dec),
        .mode         (mode),
        .latch        (latch),
        .in_value     (in_value),
        .count        (count),
        .zero         (zero),
        .term_pulse   (term_pulse)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance n rising edges; returns just after the last edge so outputs have settled.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    function automatic logic [WIDTH-1:0] pick_value();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return WIDTH'(1);
            2:       return WIDTH'(MAX_VAL - 1);
            3:       return WIDTH'(MAX_VAL);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Reference model: count values as plain integers, prescaler as cycles since last tick.
    always @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                m_count[ch]  = 0;
                m_reload[ch] = 0;
                m_term[ch]   = 0;
            end
            m_pre       = 0;
            model_valid = 1;
        end else if (model_valid) begin
            m_tick = (m_pre >= int'(prescale_div));
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (latch[ch]) begin
                    m_count[ch]  = int'(in_value[ch*WIDTH +: WIDTH]);
                    m_reload[ch] = m_count[ch];
                    m_term[ch]   = 0;
                end else if (m_tick && en[ch]) begin
                    m_cur = m_count[ch];
                    if (dec[ch]) begin
                        m_tv  = 0;
                        m_nxt = (m_cur > 0) ? m_cur - 1 : (mode[ch] ? m_reload[ch] : 0);
                    end else begin
                        m_tv  = MAX_VAL;
                        m_nxt = (m_cur < MAX_VAL) ? m_cur + 1 : (mode[ch] ? 0 : MAX_VAL);
                    end
                    m_term[ch]  = (m_nxt == m_tv) && ((m_cur != m_tv) || mode[ch]);
                    m_count[ch] = m_nxt;
                end else begin
                    m_term[ch] = 0;
                end
            end
            m_pre = m_tick ? 0 : m_pre + 1;
        end
    end

    always @(negedge clk_clk) begin
        logic [CHANNELS*WIDTH-1:0] exp_count;
        logic [CHANNELS-1:0]       exp_zero;
        logic [CHANNELS-1:0]       exp_term;
        if (model_valid) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                exp_count[ch*WIDTH +: WIDTH] = WIDTH'(m_count[ch]);
                exp_zero[ch]                 = (m_count[ch] == 0);
                exp_term[ch]                 = m_term[ch];
            end
            checkOutput("model_count", 32'(count), 32'(exp_count));
            checkOutput("model_zero", 32'(zero), 32'(exp_zero));
            checkOutput("model_term", 32'(term_pulse), 32'(exp_term));
        end
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_valid  = 0;
        m_pre        = 0;
        reset_reset  = 1'b1;
        prescale_div = '0;
        en           = '0;
        dec          = '0;
        mode         = '0;
        latch        = '0;
        in_value     = '0;
        applyStimulus(2);
        checkOutput("reset_count", 32'(count), 32'h0);
        checkOutput("reset_zero", 32'(zero), 32'hF);
        checkOutput("reset_term", 32'(term_pulse), 32'h0);
        reset_reset = 1'b0;

        // Load 3 and count down with reload.
        mode[0] = 1'b1;
        dec[0]  = 1'b1;
        latch[0] = 1'b1;
        in_value[7:0] = 8'd3;
        applyStimulus(1);
        checkOutput("r18_load", 32'(count[7:0]), 32'd3);
        latch[0] = 1'b0;
        en[0]    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1);
            checkOutput("r18_count", 32'(count[7:0]), 32'(exp18_cnt[k]));
            checkOutput("r18_term", 32'(term_pulse[0]), 32'(exp18_term[k]));
            checkOutput("r18_zero", 32'(zero[0]), 32'(exp18_cnt[k] == 0));
        end
        en[0] = 1'b0;

        // Stop at terminal counting up.
        mode[1]  = 1'b0;
        dec[1]   = 1'b0;
        latch[1] = 1'b1;
        in_value[15:8] = 8'd254;
        applyStimulus(1);
        checkOutput("r19_load", 32'(count[15:8]), 32'd254);
        latch[1] = 1'b0;
        en[1]    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1);
            checkOutput("r19_count", 32'(count[15:8]), 32'd255);
            checkOutput("r19_term", 32'(term_pulse[1]), (k == 0) ? 32'd1 : 32'd0);
        end
        en[1] = 1'b0;

        // Prescaler period of 4, then shrink the divisor below the phase.
        prescale_div = 8'd3;
        applyStimulus(3);
        latch[2] = 1'b1;
        dec[2]   = 1'b1;
        en[2]    = 1'b1;
        in_value[23:16] = 8'd10;
        applyStimulus(1);
        checkOutput("r20_load", 32'(count[23:16]), 32'd10);
        latch[2] = 1'b0;
        applyStimulus(3);
        checkOutput("r20_hold", 32'(count[23:16]), 32'd10);
        applyStimulus(1);
        checkOutput("r20_c4", 32'(count[23:16]), 32'd9);
        applyStimulus(3);
        checkOutput("r20_hold2", 32'(count[23:16]), 32'd9);
        applyStimulus(1);
        checkOutput("r20_c8", 32'(count[23:16]), 32'd8);
        applyStimulus(3);
        prescale_div = 8'd1;
        applyStimulus(1);
        checkOutput("r20_shrink", 32'(count[23:16]), 32'd7);
        en[2] = 1'b0;

        // Latch colliding with a step that would have hit terminal.
        prescale_div = 8'd0;
        latch[3] = 1'b1;
        mode[3]  = 1'b1;
        dec[3]   = 1'b0;
        in_value[31:24] = 8'd100;
        applyStimulus(1);
        latch[3] = 1'b0;
        en[3]    = 1'b1;
        en[0]    = 1'b1;
        applyStimulus(1);
        checkOutput("r21_pre", 32'(count[7:0]), 32'd1);
        latch[0] = 1'b1;
        in_value[7:0] = 8'd7;
        applyStimulus(1);
        checkOutput("r21_load", 32'(count[7:0]), 32'd7);
        checkOutput("r21_term", 32'(term_pulse[0]), 32'd0);
        checkOutput("r21_ch3", 32'(count[31:24]), 32'd102);
        latch[0] = 1'b0;
        applyStimulus(1);
        checkOutput("r21_after", 32'(count[7:0]), 32'd6);
        en[0] = 1'b0;

        // Reset in the middle of counting discards the prescaler phase.
        prescale_div = 8'd2;
        applyStimulus(4);
        reset_reset = 1'b1;
        applyStimulus(1);
        checkOutput("r22_count", 32'(count), 32'h0);
        checkOutput("r22_zero", 32'(zero), 32'hF);
        checkOutput("r22_term", 32'(term_pulse), 32'h0);
        reset_reset = 1'b0;
        applyStimulus(2);
        checkOutput("r22_wait", 32'(count[31:24]), 32'd0);
        applyStimulus(1);
        checkOutput("r22_tick", 32'(count[31:24]), 32'd1);

        // Wrap up from 255 to 0 with the pulse only on reaching 255.
        prescale_div = 8'd0;
        latch[3] = 1'b1;
        in_value[31:24] = 8'd254;
        applyStimulus(1);
        latch[3] = 1'b0;
        applyStimulus(1);
        checkOutput("r23_max", 32'(count[31:24]), 32'd255);
        checkOutput("r23_term_max", 32'(term_pulse[3]), 32'd1);
        applyStimulus(1);
        checkOutput("r23_wrap", 32'(count[31:24]), 32'd0);
        checkOutput("r23_term_wrap", 32'(term_pulse[3]), 32'd0);
        checkOutput("r23_zero", 32'(zero[3]), 32'd1);
        en[3] = 1'b0;

        // Randomized traffic, checked by the per-cycle compare process.
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset_reset  = ($urandom_range(0, 79) == 0);
            prescale_div = ($urandom_range(0, 9) == 0) ? PRE_W'($urandom_range(0, 12)) : PRE_W'($urandom_range(0, 2));
            en           = CHANNELS'($urandom);
            if ($urandom_range(0, 7) == 0) dec  = CHANNELS'($urandom);
            if ($urandom_range(0, 7) == 0) mode = CHANNELS'($urandom);
            for (int ch = 0; ch < CHANNELS; ch++) begin
                latch[ch] = ($urandom_range(0, 9) == 0);
                in_value[ch*WIDTH +: WIDTH] = pick_value();
            end
            applyStimulus(1);
        end

        reset_reset = 1'b0;
        en          = '0;
        latch       = '0;
        applyStimulus(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/param_multi_counter.md
PARAM_MULTI_COUNTER -- requirements
Module: param_multi_counter

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8, count width per channel.
- CHANNELS, default 4, number of independent counters.
- PRE_W, default 8, width of the shared prescaler.
REQ-002 Ports SHALL be as follows (clock and reset first); one clock; reset is synchronous and active-high:
- clk_clk  in  1  sole clock, rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- prescale_div  in  PRE_W  tick period minus one.
- en  in  CHANNELS  per-channel count enable.
- dec  in  CHANNELS  direction, 1 = down, 0 = up.
- mode  in  CHANNELS  1 = auto-reload/wrap, 0 = stop at terminal.
- latch  in  CHANNELS  per-channel load strobe.
- in_value  in  CHANNELS*WIDTH  packed load values; channel i at [i*WIDTH +: WIDTH].
- count  out  CHANNELS*WIDTH  packed counter values.
- zero  out  CHANNELS  count of channel i equals 0.
- term_pulse  out  CHANNELS  one-cycle terminal event.

Function
REQ-003 A shared prescaler pre_cnt (PRE_W bits) SHALL assert tick when pre_cnt >= prescale_div, clearing pre_cnt to 0 on the next edge; otherwise pre_cnt increments by 1.
REQ-004 With prescale_div = 0, tick SHALL be high every cycle; with prescale_div = N, tick SHALL occur every N+1 cycles.
REQ-005 Lowering prescale_div below the current pre_cnt SHALL produce a tick on the next cycle, with no wrap-around through 2^PRE_W.
REQ-006 Per channel i, a count step SHALL occur on a cycle where tick && en[i] && !latch[i].
REQ-007 latch[i] SHALL load in_value[i] into count[i] and into a reload register reload[i] on the next edge, regardless of tick, en or mode; latch has priority over a count step.
REQ-008 Down step (dec=1): count>0 SHALL decrement by 1; count==0 with mode=1 SHALL load reload[i]; count==0 with mode=0 SHALL hold 0.
REQ-009 Up step (dec=0): count<2^WIDTH-1 SHALL increment by 1; count==2^WIDTH-1 with mode=1 SHALL wrap to 0; with mode=0 SHALL hold at 2^WIDTH-1.
REQ-010 Terminal value SHALL be 0 when dec=1 and 2^WIDTH-1 when dec=0, evaluated with dec at the step cycle.
REQ-011 term_pulse[i] SHALL be registered and high for exactly the cycle after a count step whose result equals the terminal value, provided the pre-step value differed from terminal or mode[i]=1; a latch SHALL never raise term_pulse.
REQ-012 zero[i] SHALL be combinational from the count register (count[i]==0), so it is valid in the same cycle as count.
REQ-013 Channels SHALL be fully independent; a simultaneous latch, step or direction change on several channels SHALL affect only the channels concerned.
REQ-014 Changing dec or mode takes effect on the next step; there is no pipeline, so step latency from tick to count update SHALL be one clock.
REQ-015 Arithmetic SHALL be modulo-free: no step may produce a value outside 0..2^WIDTH-1 other than via REQ-008/009 rules.

Reset
REQ-016 While reset_reset=1 at a rising edge: count=0, reload=0, pre_cnt=0 and term_pulse=0 for all channels; zero SHALL read all ones in the following cycle.
REQ-017 Reset SHALL override latch and tick in the same cycle; asserting reset mid-count SHALL discard the prescaler phase, with the first post-reset tick after prescale_div+1 cycles.

Verification
REQ-018 Load/count down: WIDTH=8, div=0, ch0 mode=1, dec=1, latch 3, then en=1 -> count 3,2,1,0,3,2; term_pulse[0] high one cycle after 1->0; zero[0] high while count=0.
REQ-019 Stop mode: ch1 mode=0, dec=0, latch 254, en=1, div=0 -> 254,255,255,255; exactly one term_pulse[1].
REQ-020 Prescaler: div=3, ch2 latch 10, dec=1, en=1 -> count decrements once every 4 cycles (10,9,8 at cycles 4,8 after load); lowering div to 1 when pre_cnt=3 gives a tick the next cycle.
REQ-021 Collision: latch[0] with value 7 in the same cycle as a tick on ch0 -> count[0]=7 next cycle, no decrement, no term_pulse; ch3 counting concurrently is unaffected.
REQ-022 Reset mid-operation: counting at div=2, assert reset_reset one cycle -> all count=0, zero=all ones, term_pulse=0; the first tick occurs 3 cycles after reset deasserts.
REQ-023 Wrap up: mode=1, dec=0, count=255, step -> 0 with term_pulse high one cycle after reaching 255 only, not on 255->0.
